// File: rtl/byte_wq_pkg.sv
// Shared types and helpers for byte_write_queue.
// Entry fields are sized for the widest legal configuration
// (32-bit address, 32-bit word, 4 lanes); narrower builds use the low bits.
package byte_wq_pkg;

  localparam int unsigned WQ_MAX_ADDR_W = 32;
  localparam int unsigned WQ_MAX_DATA_W = 32;
  localparam int unsigned WQ_MAX_LANES  = 4;

  typedef struct packed {
    logic [WQ_MAX_ADDR_W-1:0] addr;
    logic [WQ_MAX_DATA_W-1:0] data;
    logic [WQ_MAX_LANES-1:0]  lane_valid;
  } wq_entry_t;

  function automatic int unsigned wq_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned wq_lb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Active-low bit mask: lanes marked valid become 0 (written).
  function automatic logic [WQ_MAX_DATA_W-1:0] wq_lane_mask_n(
    input logic [WQ_MAX_LANES-1:0] lane_valid
  );
    logic [WQ_MAX_DATA_W-1:0] m;
    m = '1;
    for (int unsigned l = 0; l < WQ_MAX_LANES; l++) begin
      if (lane_valid[l]) m[l*8 +: 8] = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/byte_write_queue.sv
// Byte-to-word write staging queue in front of a dual-port RAM write port.
// Ports: clk/rst_n; in_valid/in_ready/in_addr/in_data byte write input;
// wr_hold downstream stall; ADW/DI/MASK_N/WE/CEW masked word write out;
// level current entry count.
module byte_write_queue
  import byte_wq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_W = 9,
  parameter int unsigned DATA_WIDTH_W = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned LB          = wq_lb(DATA_WIDTH_W),
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH_W+LB-1:0] in_addr,
  input  logic [7:0]                 in_data,
  input  logic                       wr_hold,
  output logic [ADDR_WIDTH_W-1:0]    ADW,
  output logic [DATA_WIDTH_W-1:0]    DI,
  output logic [DATA_WIDTH_W-1:0]    MASK_N,
  output logic                       WE,
  output logic                       CEW,
  output logic [LVL_W-1:0]           level
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  wq_entry_t mem_q [FIFO_DEPTH];
  wq_entry_t mem_d [FIFO_DEPTH];
  wq_entry_t head;

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        tail_ptr;
  logic [LVL_W-1:0]        count_q, count_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH_W-1:0] adw_q, adw_d;
  logic [DATA_WIDTH_W-1:0] di_q, di_d;
  logic [DATA_WIDTH_W-1:0] mask_n_q, mask_n_d;

  logic [ADDR_WIDTH_W-1:0] in_word;
  logic [LB-1:0]           in_lane;
  logic [4:0]              byte_off;
  logic [1:0]              lane_idx;
  logic                    full, empty, accept, pop, tail_popped, merge, push;

  assign in_word  = in_addr[ADDR_WIDTH_W+LB-1:LB];
  assign in_lane  = in_addr[LB-1:0];
  assign byte_off = 5'({in_lane, 3'b000});
  assign lane_idx = 2'(in_lane);

  assign full     = (count_q == DEPTH_LVL);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign accept   = in_valid && !full;
  assign pop      = !empty && !wr_hold;
  assign tail_ptr = wr_ptr_q - PTR_W'(1);

  // The tail is leaving on this edge only when it is also the head.
  assign tail_popped = pop && (count_q == LVL_W'(1));
  assign merge = accept && !empty && !tail_popped &&
                 (mem_q[tail_ptr].addr == WQ_MAX_ADDR_W'(in_word));
  assign push  = accept && !merge;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we_d     = pop;
    adw_d    = adw_q;
    di_d     = di_q;
    mask_n_d = mask_n_q;
    head     = mem_q[rd_ptr_q];

    if (merge) begin
      mem_d[tail_ptr].data[byte_off +: 8]    = in_data;
      mem_d[tail_ptr].lane_valid[lane_idx]   = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q]                        = '0;
      mem_d[wr_ptr_q].addr                   = WQ_MAX_ADDR_W'(in_word);
      mem_d[wr_ptr_q].data[byte_off +: 8]    = in_data;
      mem_d[wr_ptr_q].lane_valid[lane_idx]   = 1'b1;
      wr_ptr_d                               = wr_ptr_q + PTR_W'(1);
    end

    // Unwritten lanes are stored as zero, so data passes straight to DI.
    if (pop) begin
      adw_d    = ADDR_WIDTH_W'(head.addr);
      di_d     = DATA_WIDTH_W'(head.data);
      mask_n_d = DATA_WIDTH_W'(wq_lane_mask_n(head.lane_valid));
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      adw_q    <= '0;
      di_q     <= '0;
      mask_n_q <= '1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      adw_q    <= adw_d;
      di_q     <= di_d;
      mask_n_q <= mask_n_d;
    end
  end

  // Entry storage needs no reset: count/pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ADW    = adw_q;
  assign DI     = di_q;
  assign MASK_N = mask_n_q;
  assign WE     = we_q;
  assign CEW    = we_q;
  assign level  = count_q;

endmodule

// File: tb/tb_byte_write_queue.sv
module tb_byte_write_queue;

  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NVEC  = 28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_addr;
  logic [7:0]  in_data;
  logic        wr_hold;
  logic [8:0]  ADW;
  logic [15:0] DI;
  logic [15:0] MASK_N;
  logic        WE;
  logic        CEW;
  logic [2:0]  level;

  byte_write_queue #(
    .ADDR_WIDTH_W(AW),
    .DATA_WIDTH_W(DW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr (in_addr),
    .in_data (in_data),
    .wr_hold (wr_hold),
    .ADW     (ADW),
    .DI      (DI),
    .MASK_N  (MASK_N),
    .WE      (WE),
    .CEW     (CEW),
    .level   (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic        valid;
    logic [9:0]  addr;
    logic [7:0]  data;
    logic        we;
    logic [8:0]  adw;
    logic [15:0] di;
    logic [15:0] mask_n;
    logic [2:0]  lvl;
    logic        rdy;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] ref_mem [8];
  logic [15:0] ram_mdl [8];

  function automatic vec_t mk(logic h, logic v, logic [9:0] a, logic [7:0] d,
                              logic we, logic [8:0] adw, logic [15:0] di,
                              logic [15:0] m, logic [2:0] lvl, logic rdy);
    vec_t r;
    r.hold = h; r.valid = v; r.addr = a; r.data = d;
    r.we = we; r.adw = adw; r.di = di; r.mask_n = m; r.lvl = lvl; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic [9:0] a, input logic [7:0] d);
    wr_hold  = h;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic check_out(input string tag, input logic we, input logic [8:0] adw,
                           input logic [15:0] di, input logic [15:0] m,
                           input logic [2:0] lvl, input logic rdy);
    chk({tag, "_we"},     32'(WE),       32'(we));
    chk({tag, "_cew"},    32'(CEW),      32'(we));
    chk({tag, "_adw"},    32'(ADW),      32'(adw));
    chk({tag, "_di"},     32'(DI),       32'(di));
    chk({tag, "_mask_n"}, 32'(MASK_N),   32'(m));
    chk({tag, "_level"},  32'(level),    32'(lvl));
    chk({tag, "_ready"},  32'(in_ready), 32'(rdy));
  endtask

  initial begin
    // single byte, merge under hold, full/backpressure, pop-vs-merge, merge behind head
    vecs[0]  = mk(0, 1, 10'h005, 8'hA5, 0, 9'd0, 16'h0000, 16'hFFFF, 3'd1, 1);
    vecs[1]  = mk(0, 0, 10'h000, 8'h00, 1, 9'd2, 16'hA500, 16'h00FF, 3'd0, 1);
    vecs[2]  = mk(0, 0, 10'h000, 8'h00, 0, 9'd2, 16'hA500, 16'h00FF, 3'd0, 1);
    vecs[3]  = mk(1, 1, 10'h010, 8'h34, 0, 9'd2, 16'hA500, 16'h00FF, 3'd1, 1);
    vecs[4]  = mk(1, 1, 10'h011, 8'h12, 0, 9'd2, 16'hA500, 16'h00FF, 3'd1, 1);
    vecs[5]  = mk(1, 1, 10'h011, 8'h56, 0, 9'd2, 16'hA500, 16'h00FF, 3'd1, 1);
    vecs[6]  = mk(0, 0, 10'h000, 8'h00, 1, 9'd8, 16'h5634, 16'h0000, 3'd0, 1);
    vecs[7]  = mk(0, 0, 10'h000, 8'h00, 0, 9'd8, 16'h5634, 16'h0000, 3'd0, 1);
    vecs[8]  = mk(1, 1, 10'h000, 8'h11, 0, 9'd8, 16'h5634, 16'h0000, 3'd1, 1);
    vecs[9]  = mk(1, 1, 10'h002, 8'h22, 0, 9'd8, 16'h5634, 16'h0000, 3'd2, 1);
    vecs[10] = mk(1, 1, 10'h004, 8'h33, 0, 9'd8, 16'h5634, 16'h0000, 3'd3, 1);
    vecs[11] = mk(1, 1, 10'h006, 8'h44, 0, 9'd8, 16'h5634, 16'h0000, 3'd4, 0);
    vecs[12] = mk(1, 1, 10'h008, 8'h55, 0, 9'd8, 16'h5634, 16'h0000, 3'd4, 0);
    vecs[13] = mk(0, 1, 10'h008, 8'h55, 1, 9'd0, 16'h0011, 16'hFF00, 3'd3, 1);
    vecs[14] = mk(0, 1, 10'h008, 8'h55, 1, 9'd1, 16'h0022, 16'hFF00, 3'd3, 1);
    vecs[15] = mk(0, 0, 10'h000, 8'h00, 1, 9'd2, 16'h0033, 16'hFF00, 3'd2, 1);
    vecs[16] = mk(0, 0, 10'h000, 8'h00, 1, 9'd3, 16'h0044, 16'hFF00, 3'd1, 1);
    vecs[17] = mk(0, 0, 10'h000, 8'h00, 1, 9'd4, 16'h0055, 16'hFF00, 3'd0, 1);
    vecs[18] = mk(0, 0, 10'h000, 8'h00, 0, 9'd4, 16'h0055, 16'hFF00, 3'd0, 1);
    vecs[19] = mk(1, 1, 10'h00A, 8'h66, 0, 9'd4, 16'h0055, 16'hFF00, 3'd1, 1);
    vecs[20] = mk(0, 1, 10'h00B, 8'h77, 1, 9'd5, 16'h0066, 16'hFF00, 3'd1, 1);
    vecs[21] = mk(0, 0, 10'h000, 8'h00, 1, 9'd5, 16'h7700, 16'h00FF, 3'd0, 1);
    vecs[22] = mk(0, 0, 10'h000, 8'h00, 0, 9'd5, 16'h7700, 16'h00FF, 3'd0, 1);
    vecs[23] = mk(1, 1, 10'h00C, 8'h01, 0, 9'd5, 16'h7700, 16'h00FF, 3'd1, 1);
    vecs[24] = mk(1, 1, 10'h00E, 8'h02, 0, 9'd5, 16'h7700, 16'h00FF, 3'd2, 1);
    vecs[25] = mk(0, 1, 10'h00F, 8'h03, 1, 9'd6, 16'h0001, 16'hFF00, 3'd1, 1);
    vecs[26] = mk(0, 0, 10'h000, 8'h00, 1, 9'd7, 16'h0302, 16'h0000, 3'd0, 1);
    vecs[27] = mk(0, 0, 10'h000, 8'h00, 0, 9'd7, 16'h0302, 16'h0000, 3'd0, 1);

    rst_n = 1'b0;
    drive(0, 0, '0, '0);
    repeat (2) @(negedge clk);
    check_out("reset", 0, 9'd0, 16'h0000, 16'hFFFF, 3'd0, 1);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].hold, vecs[i].valid, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check_out($sformatf("v%0d", i), vecs[i].we, vecs[i].adw, vecs[i].di,
                vecs[i].mask_n, vecs[i].lvl, vecs[i].rdy);
    end

    // Reset with three entries queued under hold.
    drive(1, 1, 10'h002, 8'hA1); @(negedge clk);
    drive(1, 1, 10'h004, 8'hA2); @(negedge clk);
    drive(1, 1, 10'h006, 8'hA3); @(negedge clk);
    chk("pre_reset_level", 32'(level), 32'd3);
    drive(0, 0, '0, '0);
    rst_n = 1'b0;
    #1;
    check_out("midreset", 0, 9'd0, 16'h0000, 16'hFFFF, 3'd0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_we%0d", i), 32'(WE), 32'd0);
      chk($sformatf("post_reset_level%0d", i), 32'(level), 32'd0);
    end

    // Random soak against a byte-level reference memory.
    for (int w = 0; w < 8; w++) begin
      ref_mem[w] = '0;
      ram_mdl[w] = '0;
    end
    begin
      logic [2:0] prev_level;
      int         hold_pct;
      prev_level = level;
      hold_pct   = 10;
      for (int c = 0; c < 10000; c++) begin
        if (WE) begin
          chk("soak_adw_range", 32'(ADW >= 9'd8), 32'd0);
          chk("soak_we_nonempty", 32'(prev_level == 3'd0), 32'd0);
          ram_mdl[ADW[2:0]] = (ram_mdl[ADW[2:0]] & MASK_N) | (DI & ~MASK_N);
        end
        chk("soak_level_bound", 32'(level > 3'(DEPTH)), 32'd0);
        prev_level = level;
        if (c % 500 == 0) hold_pct = (c / 500 % 3 == 0) ? 10 : (c / 500 % 3 == 1) ? 50 : 90;
        drive(($urandom_range(0, 99) < hold_pct), ($urandom_range(0, 99) < 60),
              10'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        if (in_valid && in_ready) begin
          if (in_addr[0]) ref_mem[in_addr[3:1]][15:8] = in_data;
          else            ref_mem[in_addr[3:1]][7:0]  = in_data;
        end
        @(negedge clk);
      end
      drive(0, 0, '0, '0);
      for (int c = 0; c < DEPTH + 4; c++) begin
        if (WE) ram_mdl[ADW[2:0]] = (ram_mdl[ADW[2:0]] & MASK_N) | (DI & ~MASK_N);
        @(negedge clk);
      end
      chk("soak_drained_level", 32'(level), 32'd0);
      chk("soak_drained_we", 32'(WE), 32'd0);
      for (int w = 0; w < 8; w++) begin
        chk($sformatf("soak_ram_word%0d", w), 32'(ram_mdl[w]), 32'(ref_mem[w]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_write_queue.md
# byte_write_queue

Byte-to-word write staging queue that sits directly upstream of the generic dual-port RAM write port (palette / sprite-attribute RAM). It accepts 8-bit CPU-side byte writes, buffers them in a small FIFO, and merges same-word bytes while the RAM port is held off. It drains them as masked word writes (ADW/DI/MASK_N/WE/CEW) with active-low per-bit mask semantics.

## Interface
- ADDR_WIDTH_W, 9, word address width of the downstream RAM write port
- DATA_WIDTH_W, 16, RAM word width; legal values 16 or 32 (LANES = DATA_WIDTH_W/8, LB = log2(LANES))
- FIFO_DEPTH, 4, queue entries; power of two, 2..16
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte write request
- in_ready  out  1  queue can accept; equals !full
- in_addr  in  ADDR_WIDTH_W+LB  byte address {word address, lane}
- in_data  in  8  byte data
- wr_hold  in  1  downstream port busy; no pop while high
- ADW  out  ADDR_WIDTH_W  RAM write word address
- DI  out  DATA_WIDTH_W  RAM write data
- MASK_N  out  DATA_WIDTH_W  active-low bit mask; 0 = bit written
- WE  out  1  write strobe, one cycle per entry
- CEW  out  1  write clock enable; driven identical to WE
- level  out  log2(FIFO_DEPTH)+1  current entry count

## Operation
- Entry fields: word address, DATA_WIDTH_W data, LANES-bit lane-valid vector.
- Accept happens when in_valid && in_ready at a clock edge.
- Merge rule: an accepted byte merges into the tail entry instead of pushing when all of these hold:
  - the queue is non-empty;
  - the tail word address equals in_addr[ADDR_WIDTH_W+LB-1:LB];
  - the tail entry is not being popped on that same edge.
- Merge effect: set the lane-valid bit and overwrite that lane's byte. A repeat write to the same lane is last-write-wins.
- Only the tail entry may merge. Write ordering across words is always preserved.
- Otherwise the byte pushes a new entry with only its own lane valid.
- Pop: when the queue is non-empty and wr_hold is low, pop the head entry into the output registers:
  - WE = CEW = 1;
  - ADW = entry address;
  - DI = entry data, with unwritten lanes 0;
  - MASK_N lane bits = 0 for valid lanes, 1 otherwise.
- When nothing is popped, WE = CEW = 0 on the next cycle. ADW, DI and MASK_N hold their last values.
- Full: in_ready = 0 even if a merge would be possible. Push and pop on the same edge while not full keeps level unchanged.
- Empty: no WE. wr_hold has no effect on acceptance.
- Reset mid-operation discards all queued entries; a partially merged word is lost.
- Reset values:
  - WE = 0, CEW = 0;
  - ADW = 0, DI = 0, MASK_N = all ones;
  - level = 0, in_ready = 1;
  - read and write pointers = 0.

## Timing
- in_ready is combinational from the registered count only. There is no combinational path from in_valid or wr_hold to in_ready.
- Latency, empty queue with wr_hold low: a byte accepted at edge k drives WE high in the cycle after edge k+1 (two edges).
- Throughput: one WE per cycle while the queue is non-empty and wr_hold is low.
- Merging only occurs when the tail is not popped: under wr_hold, or when the queue holds at least 2 entries.
- wr_hold is sampled at the pop edge. Raising it blocks the pop on that edge. The already-registered WE cycle is not affected.
- Pointer wrap-around is modulo FIFO_DEPTH. level distinguishes full from empty.

## Structure
- Shared package byte_wq_pkg holds:
  - the entry struct typedef (addr, data, lane_valid);
  - the LANES/LB derivation function;
  - a lane-to-mask expansion function.
- No sub-module. The FIFO is flat because the merge logic needs direct write access to the tail entry.

## Test plan
- Reset/idle: assert rst_n low mid-stream with 3 entries queued, then release -> WE = 0, MASK_N = 16'hFFFF, level = 0, in_ready = 1; no WE afterwards.
- Single byte: wr_hold = 0; write addr 0x005 (word 2, lane 1), data 0xA5 -> two edges later one WE cycle with ADW = 2, DI = 16'hA500, MASK_N = 16'h00FF.
- Merge under hold: wr_hold = 1; write 0x010 = 0x34, 0x011 = 0x12, 0x011 = 0x56; release hold -> single WE with ADW = 8, DI = 16'h5634, MASK_N = 16'h0000; level goes 1→0.
- Full/backpressure: wr_hold = 1; push bytes to words 0,1,2,3 -> level = 4, in_ready = 0; a fifth byte is held off. Release hold -> four WE cycles in order 0,1,2,3, then the fifth is accepted.
- Simultaneous pop/merge: queue holds one entry for word 5 lane 0 with wr_hold falling; a lane-1 byte to word 5 arrives on the pop edge -> two separate WEs: MASK_N = 16'hFF00, then 16'h00FF.
- Random soak: random in_valid/wr_hold for 10k cycles vs. a reference memory model -> final RAM contents match; no WE while empty; level never exceeds FIFO_DEPTH.
